// File: rtl/_reduce_seq_if.sv
// Producer/consumer handshake bundle for the chunked reduction engine.
// The master drives operands and result acceptance; the slave (the engine) answers.
interface _reduce_seq_if #(
    parameter int INPUT_WIDTH = 8
);
    logic                   inValid;
    logic                   inReady;
    logic [2:0]             mode;
    logic [INPUT_WIDTH-1:0] inputData;
    logic                   outValid;
    logic                   outReady;
    logic                   outputData;
    logic                   modeError;
    logic                   busy;

    modport master (
        output inValid, mode, inputData, outReady,
        input  inReady, outValid, outputData, modeError, busy
    );

    modport slave (
        input  inValid, mode, inputData, outReady,
        output inReady, outValid, outputData, modeError, busy
    );
endinterface

// File: rtl/_reduce_seq.sv
// Clocked N-input NAND/AND/NOR/OR/XOR/XNOR reduction, folding CHUNK_WIDTH bits per clock.
//   state | meaning
//   IDLE  | waiting for an operand; inReady high once out of reset
//   RUN   | folding one chunk per clock into the accumulator
//   DONE  | result presented on outValid until the consumer takes it
module _reduce_seq #(
    parameter int INPUT_WIDTH = 8,
    parameter int CHUNK_WIDTH = 4
) (
    input logic          clock,
    input logic          resetN,
    _reduce_seq_if.slave bus
);
    localparam int NUM_CHUNKS = (INPUT_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int PAD_WIDTH  = NUM_CHUNKS * CHUNK_WIDTH;
    localparam int CNT_WIDTH  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    if (CHUNK_WIDTH < 1 || CHUNK_WIDTH > INPUT_WIDTH) begin : g_cfg_check
        $error("_reduce_seq: CHUNK_WIDTH must lie within 1..INPUT_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   started;
    logic [2:0]             mode_q;
    logic [PAD_WIDTH-1:0]   data_q;
    logic [PAD_WIDTH-1:0]   data_padded;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CHUNK_WIDTH-1:0] chunk;
    logic                   acc;
    logic                   acc_fold;
    logic                   ident_in;
    logic                   accept;
    logic                   last_chunk;
    logic                   reserved;
    logic                   invert;

    // AND-type modes start from 1, everything else from 0; the same value pads the last chunk.
    assign ident_in = (bus.mode[2:1] == 2'b00);

    for (genvar i = 0; i < PAD_WIDTH; i++) begin : g_pad
        if (i < INPUT_WIDTH) begin : g_data
            assign data_padded[i] = bus.inputData[i];
        end else begin : g_fill
            assign data_padded[i] = ident_in;
        end
    end

    assign accept     = bus.inValid && started && (state == IDLE);
    assign last_chunk = (cnt == '0);
    assign chunk      = data_q[CHUNK_WIDTH-1:0];
    assign reserved   = (mode_q[2:1] == 2'b11);
    assign invert     = mode_q[2] ? mode_q[0] : ~mode_q[0];

    always_comb begin
        case (mode_q[2:1])
            2'b00:   acc_fold = acc & (&chunk);
            2'b01:   acc_fold = acc | (|chunk);
            2'b10:   acc_fold = acc ^ (^chunk);
            default: acc_fold = acc;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)       state_next = RUN;
            RUN:     if (last_chunk)   state_next = DONE;
            DONE:    if (bus.outReady) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Operand is consumed as a shift register; the down-counter marks the final chunk.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            started <= 1'b0;
            mode_q  <= 3'b000;
            data_q  <= '0;
            cnt     <= '0;
            acc     <= 1'b0;
        end else begin
            started <= 1'b1;
            if (accept) begin
                mode_q <= bus.mode;
                data_q <= data_padded;
                cnt    <= CNT_WIDTH'(NUM_CHUNKS - 1);
                acc    <= ident_in;
            end else if (state == RUN) begin
                acc    <= acc_fold;
                data_q <= data_q >> CHUNK_WIDTH;
                cnt    <= cnt - CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        bus.inReady    = 1'b0;
        bus.outValid   = 1'b0;
        bus.busy       = 1'b0;
        bus.outputData = 1'b0;
        bus.modeError  = 1'b0;
        case (state)
            IDLE: bus.inReady = started;
            RUN:  bus.busy    = 1'b1;
            DONE: begin
                bus.busy       = 1'b1;
                bus.outValid   = 1'b1;
                bus.outputData = !reserved && (acc ^ invert);
                bus.modeError  = reserved;
            end
            default: ;
        endcase
    end
endmodule
